// File: rtl/piccolo80_dec_if.sv
// -----------------------------------------------------------------------------
// piccolo80_dec_if
// Handshake bundle for the Piccolo-80 decryption core.
//   in_valid   : source -> core, ciphertext and key are valid
//   in_ready   : core -> source, core can accept a block (IDLE only)
//   ciphertext : 64-bit block, bit 0 (MSB) first, words X0..X3 high to low
//   keyin      : 80-bit key, words k0..k4 high to low
//   out_valid  : core -> sink, plaintext is valid
//   out_ready  : sink -> core, plaintext accepted
//   plaintext  : 64-bit decrypted block, same ordering as ciphertext
// master = block source/sink side, slave = decryption core.
// -----------------------------------------------------------------------------
interface piccolo80_dec_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic [79:0] keyin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;

  modport master (
    output in_valid, ciphertext, keyin, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, keyin, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/piccolo80_dec.sv
// -----------------------------------------------------------------------------
// piccolo80_dec
// Iterative Piccolo-80 decryption: one round per clock, 25 rounds, round keys
// derived on the fly (in reverse encryption order) from the latched key.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : piccolo80_dec_if.slave handshake (ciphertext/key in, plaintext out)
// Timing: accept at edge E0, out_valid high after edge E25. A new block is
// only taken in IDLE, so blocks are spaced at least 27 cycles apart.
// -----------------------------------------------------------------------------
module piccolo80_dec #(
  parameter int ROUNDS = 25
) (
  input  logic              clk,
  input  logic              reset,
  piccolo80_dec_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  // ---------------------------------------------------------------------------
  // Cipher helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] sbox_f(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'he;  4'h1: r = 4'h4;  4'h2: r = 4'hb;  4'h3: r = 4'h2;
      4'h4: r = 4'h3;  4'h5: r = 4'h8;  4'h6: r = 4'h0;  4'h7: r = 4'h9;
      4'h8: r = 4'h1;  4'h9: r = 4'ha;  4'ha: r = 4'h7;  4'hb: r = 4'hf;
      4'hc: r = 4'h6;  4'hd: r = 4'hc;  4'he: r = 4'h5;  4'hf: r = 4'hd;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  // Multiply by x in GF(2^4) mod x^4+x+1: x^4 folds back to x+1.
  function automatic logic [3:0] gm2_f(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gm3_f(input logic [3:0] a);
    return gm2_f(a) ^ a;
  endfunction

  // F: S-layer, diffusion matrix M (circulant 2,3,1,1), S-layer.
  function automatic logic [15:0] f_func(input logic [15:0] x);
    logic [3:0] s0, s1, s2, s3;
    logic [3:0] y0, y1, y2, y3;
    s0 = sbox_f(x[15:12]);
    s1 = sbox_f(x[11:8]);
    s2 = sbox_f(x[7:4]);
    s3 = sbox_f(x[3:0]);
    y0 = gm2_f(s0) ^ gm3_f(s1) ^ s2        ^ s3;
    y1 = s0        ^ gm2_f(s1) ^ gm3_f(s2) ^ s3;
    y2 = s0        ^ s1        ^ gm2_f(s2) ^ gm3_f(s3);
    y3 = gm3_f(s0) ^ s1        ^ s2        ^ gm2_f(s3);
    return {sbox_f(y0), sbox_f(y1), sbox_f(y2), sbox_f(y3)};
  endfunction

  // Byte permutation RP: (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5), b0 = MSB byte.
  function automatic logic [63:0] rp_f(input logic [63:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48],
            x[15:8],  x[39:32], x[63:56], x[23:16]};
  endfunction

  // Round constant pair for encryption round j, c = j+1 on 5 bits.
  function automatic logic [31:0] con_f(input logic [4:0] j);
    logic [4:0] c;
    c = j + 5'd1;
    return {c, 5'b00000, c, 2'b00, c, 5'b00000, c} ^ 32'h0f1e2d3c;
  endfunction

  // Whitening keys; k0..k4 = key[79:64]..key[15:0], "L" byte = upper byte.
  function automatic logic [15:0] wk0_f(input logic [79:0] k);
    return {k[79:72], k[55:48]};
  endfunction

  function automatic logic [15:0] wk1_f(input logic [79:0] k);
    return {k[63:56], k[71:64]};
  endfunction

  function automatic logic [15:0] wk2_f(input logic [79:0] k);
    return {k[15:8], k[23:16]};
  endfunction

  function automatic logic [15:0] wk3_f(input logic [79:0] k);
    return {k[31:24], k[7:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [4:0]  cnt_q;       // decryption round index i
  logic [2:0]  mod5_q;      // (24 - i) mod 5, selects the key schedule word pair
  logic [63:0] x_q;         // cipher state X0..X3
  logic [79:0] key_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] plain_q;

  // Combinational round datapath
  logic [4:0]  j_s;
  logic [31:0] sched_s;
  logic [31:0] rk_pair_s;
  logic [15:0] rk_a_s;
  logic [15:0] rk_b_s;
  logic [15:0] x1_s;
  logic [15:0] x3_s;
  logic        last_s;
  logic [63:0] x_d;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plaintext = plain_q;

  // One decryption round on x_q, using encryption round j = 24 - i keys.
  always_comb begin
    j_s    = LAST_RND - cnt_q;
    last_s = (cnt_q == LAST_RND);
    case (mod5_q)
      3'd0, 3'd2: sched_s = key_q[47:16];                  // {k2,k3}
      3'd1, 3'd4: sched_s = key_q[79:48];                  // {k0,k1}
      3'd3:       sched_s = {key_q[15:0], key_q[15:0]};    // {k4,k4}
      default:    sched_s = 32'h0000_0000;
    endcase
    rk_pair_s = con_f(j_s) ^ sched_s;
    // Odd decryption rounds use the pair swapped; this undoes the RP
    // asymmetry so the forward round structure can be reused.
    if (cnt_q[0]) begin
      rk_a_s = rk_pair_s[15:0];
      rk_b_s = rk_pair_s[31:16];
    end else begin
      rk_a_s = rk_pair_s[31:16];
      rk_b_s = rk_pair_s[15:0];
    end
    x1_s = x_q[47:32] ^ f_func(x_q[63:48]) ^ rk_a_s;
    x3_s = x_q[15:0]  ^ f_func(x_q[31:16]) ^ rk_b_s;
    // Final round: no RP, post-whitening folded into the same cycle.
    if (last_s) begin
      x_d = {x_q[63:48] ^ wk0_f(key_q), x1_s, x_q[31:16] ^ wk1_f(key_q), x3_s};
    end else begin
      x_d = rp_f({x_q[63:48], x1_s, x_q[31:16], x3_s});
    end
  end

  // Control FSM with registered handshake outputs and plaintext register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      mod5_q      <= 3'd0;
      x_q         <= 64'h0;
      key_q       <= 80'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      plain_q     <= 64'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            key_q      <= bus.keyin;
            x_q        <= {bus.ciphertext[63:48] ^ wk2_f(bus.keyin),
                           bus.ciphertext[47:32],
                           bus.ciphertext[31:16] ^ wk3_f(bus.keyin),
                           bus.ciphertext[15:0]};
            cnt_q      <= 5'd0;
            mod5_q     <= 3'd4;            // 24 mod 5
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          x_q    <= x_d;
          cnt_q  <= cnt_q + 5'd1;
          mod5_q <= (mod5_q == 3'd0) ? 3'd4 : mod5_q - 3'd1;
          if (last_s) begin
            plain_q     <= x_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piccolo80_dec.sv
// -----------------------------------------------------------------------------
// tb_piccolo80_dec
// Self-checking bench for piccolo80_dec: a vector table (published vector plus
// blocks encrypted by an independent Piccolo-80 encryption model) and directed
// sequences for backpressure, busy-ignore, async reset and back-to-back.
// -----------------------------------------------------------------------------
module tb_piccolo80_dec;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  piccolo80_dec_if bus ();

  piccolo80_dec #(.ROUNDS(25)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  localparam logic [79:0] PUB_KEY = 80'h00112233445566778899;
  localparam logic [63:0] PUB_CT  = 64'h8d2bff9935f84056;
  localparam logic [63:0] PUB_PT  = 64'h0123456789abcdef;

  // ---------------- encryption reference model ----------------
  function automatic logic [3:0] m_sbox(input logic [3:0] a);
    logic [63:0] tbl;
    tbl = 64'he4b238091a7f6c5d;
    return tbl[63 - 4*a -: 4];
  endfunction

  function automatic logic [3:0] m_x2(input logic [3:0] a);
    logic [4:0] t;
    t = {a, 1'b0};
    if (t[4]) t = t ^ 5'b10011;
    return t[3:0];
  endfunction

  function automatic logic [15:0] m_f(input logic [15:0] x);
    logic [3:0] s [4];
    logic [3:0] y [4];
    logic [15:0] r;
    for (int n = 0; n < 4; n++) s[n] = m_sbox(x[15 - 4*n -: 4]);
    for (int n = 0; n < 4; n++)
      y[n] = m_x2(s[n]) ^ m_x2(s[(n+1)%4]) ^ s[(n+1)%4] ^ s[(n+2)%4] ^ s[(n+3)%4];
    for (int n = 0; n < 4; n++) r[15 - 4*n -: 4] = m_sbox(y[n]);
    return r;
  endfunction

  function automatic logic [63:0] m_enc(input logic [79:0] k, input logic [63:0] p);
    logic [15:0] kw [5];
    logic [15:0] x  [4];
    logic [7:0]  b  [8];
    logic [7:0]  nb [8];
    logic [31:0] sch, con, rk;
    logic [4:0]  c;
    int          perm [8];
    perm = '{2, 7, 4, 1, 6, 3, 0, 5};
    for (int n = 0; n < 5; n++) kw[n] = k[79 - 16*n -: 16];
    for (int n = 0; n < 4; n++) x[n] = p[63 - 16*n -: 16];
    x[0] ^= {kw[0][15:8], kw[1][7:0]};
    x[2] ^= {kw[1][15:8], kw[0][7:0]};
    for (int j = 0; j < 25; j++) begin
      case (j % 5)
        0, 2:    sch = {kw[2], kw[3]};
        1, 4:    sch = {kw[0], kw[1]};
        default: sch = {kw[4], kw[4]};
      endcase
      c   = 5'(j + 1);
      con = {c, 5'd0, c, 2'd0, c, 5'd0, c} ^ 32'h0f1e2d3c;
      rk  = con ^ sch;
      x[1] ^= m_f(x[0]) ^ rk[31:16];
      x[3] ^= m_f(x[2]) ^ rk[15:0];
      if (j < 24) begin
        for (int n = 0; n < 4; n++) begin
          b[2*n]   = x[n][15:8];
          b[2*n+1] = x[n][7:0];
        end
        for (int n = 0; n < 8; n++) nb[n] = b[perm[n]];
        for (int n = 0; n < 4; n++) x[n] = {nb[2*n], nb[2*n+1]};
      end
    end
    x[0] ^= {kw[4][15:8], kw[3][7:0]};
    x[2] ^= {kw[3][15:8], kw[4][7:0]};
    return {x[0], x[1], x[2], x[3]};
  endfunction

  // ---------------- check helpers ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for out_valid; cyc counts edges since the accept edge.
  task automatic wait_out(input int start, output int cyc);
    cyc = start;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_int("out_valid drops after handshake", int'(bus.out_valid), 0);
    check_int("in_ready back after handshake", int'(bus.in_ready), 1);
  endtask

  task automatic accept(input logic [79:0] key, input logic [63:0] ct);
    check_int("in_ready before accept", int'(bus.in_ready), 1);
    bus.keyin      = key;
    bus.ciphertext = ct;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic run_block(input string name, input vec_t v);
    int cyc;
    accept(v.key, v.ct);
    wait_out(0, cyc);
    check_int({name, " latency"}, cyc, 25);
    check64(name, bus.plaintext, v.pt);
    handshake();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t        vecs [8];
    logic [95:0] r;
    vec_t        v;
    int          cyc;
    logic [63:0] held;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ciphertext = 64'h0;
    bus.keyin      = 80'h0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_int("reset in_ready", int'(bus.in_ready), 1);
    check_int("reset out_valid", int'(bus.out_valid), 0);
    check64("reset plaintext", bus.plaintext, 64'h0);

    // Vector table
    vecs[0] = '{PUB_KEY, PUB_CT, PUB_PT};
    vecs[1] = '{80'h0, m_enc(80'h0, 64'h0), 64'h0};
    vecs[2] = '{{80{1'b1}}, m_enc({80{1'b1}}, {64{1'b1}}), {64{1'b1}}};
    vecs[3] = '{80'h0123456789abcdef0123, m_enc(80'h0123456789abcdef0123, 64'hfedcba9876543210),
                64'hfedcba9876543210};
    vecs[4] = '{80'h80000000000000000000, m_enc(80'h80000000000000000000, 64'h0000000000000001),
                64'h0000000000000001};
    for (int n = 5; n < 8; n++) begin
      r       = {$urandom(), $urandom(), $urandom()};
      v.key   = r[79:0];
      v.pt    = {$urandom(), $urandom()};
      v.ct    = m_enc(v.key, v.pt);
      vecs[n] = v;
    end
    for (int n = 0; n < 8; n++) run_block($sformatf("vec%0d", n), vecs[n]);

    // Random round trips
    for (int n = 0; n < 20; n++) begin
      r     = {$urandom(), $urandom(), $urandom()};
      v.key = r[79:0];
      v.pt  = {$urandom(), $urandom()};
      v.ct  = m_enc(v.key, v.pt);
      run_block($sformatf("roundtrip%0d", n), v);
    end

    // Backpressure: hold out_ready low for 10 cycles after completion
    accept(PUB_KEY, PUB_CT);
    wait_out(0, cyc);
    check_int("bp latency", cyc, 25);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      check_int("bp out_valid held", int'(bus.out_valid), 1);
      check64("bp plaintext held", bus.plaintext, PUB_PT);
      check_int("bp in_ready low", int'(bus.in_ready), 0);
    end
    handshake();
    check64("plaintext kept after handshake", bus.plaintext, PUB_PT);

    // Busy ignore: different block offered during RUN
    accept(PUB_KEY, PUB_CT);
    bus.out_ready = 1'b1;       // outside DONE this must be ignored
    @(posedge clk); #1;
    bus.out_ready  = 1'b0;
    bus.keyin      = 80'hdeadbeefcafebabe1234;
    bus.ciphertext = 64'h0f0f0f0f0f0f0f0f;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    check_int("busy in_ready low", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(3, cyc);
    check_int("busy latency", cyc, 25);
    check64("busy ignore result", bus.plaintext, PUB_PT);
    handshake();

    // Async reset at round 12, off a clock edge
    accept(vecs[3].key, vecs[3].ct);
    repeat (12) begin
      @(posedge clk); #1;
    end
    #3 reset = 1'b1;
    #1;
    check_int("async reset in_ready", int'(bus.in_ready), 1);
    check_int("async reset out_valid", int'(bus.out_valid), 0);
    check64("async reset plaintext", bus.plaintext, 64'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_block("after reset", vecs[0]);

    // Back-to-back with in_valid held high
    bus.keyin      = vecs[5].key;
    bus.ciphertext = vecs[5].ct;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    wait_out(0, cyc);
    check_int("b2b first latency", cyc, 25);
    check64("b2b first", bus.plaintext, vecs[5].pt);
    bus.keyin      = vecs[6].key;
    bus.ciphertext = vecs[6].ct;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.out_ready  = 1'b0;
    check_int("b2b idle after handshake", int'(bus.in_ready), 1);
    check_int("b2b out_valid low", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_int("b2b second accepted", int'(bus.in_ready), 0);
    wait_out(0, cyc);
    check_int("b2b second latency", cyc, 25);
    check64("b2b second", bus.plaintext, vecs[6].pt);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
